// File: rtl/issue_unit_if.sv
// Instruction offer channel between the decoder (master) and the issue stage (slave).
`timescale 1ns/1ps
interface issue_unit_if #(
   parameter int unsigned FUNC_W = 4,
   parameter int unsigned REG_W  = 5
);
   logic              ins_valid;
   logic              ins_ready;
   logic [FUNC_W-1:0] ins_op;
   logic              ins_halt;
   logic [REG_W-1:0]  ins_rd;
   logic [REG_W-1:0]  ins_rs0;
   logic [REG_W-1:0]  ins_rs1;

   modport master (
      output ins_valid, ins_op, ins_halt, ins_rd, ins_rs0, ins_rs1,
      input  ins_ready
   );

   modport slave (
      input  ins_valid, ins_op, ins_halt, ins_rd, ins_rs0, ins_rs1,
      output ins_ready
   );
endinterface

// File: rtl/issue_unit.sv
// In-order issue stage: scoreboarded operand read, fixed-latency writeback slot
// reservation on the shared result bus, and halt/drain sequencing toward execute.
`timescale 1ns/1ps
module issue_unit #(
   parameter int unsigned FUNC_W  = 4,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned LAT_LIN = 4,
   parameter int unsigned LAT_TPL = 4,
   parameter int unsigned LAT_MUL = 21,
   parameter int unsigned LAT_INV = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   issue_unit_if.slave        ins,
   output logic [REG_W-1:0]   rf_raddr0,
   output logic [REG_W-1:0]   rf_raddr1,
   input  logic [WORD_W-1:0]  rf_rdata0,
   input  logic [WORD_W-1:0]  rf_rdata1,
   input  logic               wen_ex,
   input  logic [REG_W-1:0]   waddr_ex,
   output logic [FUNC_W-1:0]  func_op,
   output logic               ex_valid,
   output logic [WORD_W-1:0]  op_0,
   output logic [WORD_W-1:0]  op_1,
   output logic [REG_W-1:0]   rn_df,
   output logic               halt_ex,
   output logic               busy
);

   localparam int unsigned NREG   = 1 << REG_W;
   localparam int unsigned WBW_A  = (LAT_LIN > LAT_TPL) ? LAT_LIN : LAT_TPL;
   localparam int unsigned WBW_B  = (LAT_MUL > LAT_INV) ? LAT_MUL : LAT_INV;
   localparam int unsigned WBW    = (WBW_A > WBW_B) ? WBW_A : WBW_B;
   localparam int unsigned CNT_W  = $clog2(LAT_INV + 1);

   localparam logic [FUNC_W-1:0] OP_ADD = FUNC_W'(1);
   localparam logic [FUNC_W-1:0] OP_SUB = FUNC_W'(2);
   localparam logic [FUNC_W-1:0] OP_NEG = FUNC_W'(3);
   localparam logic [FUNC_W-1:0] OP_DBL = FUNC_W'(4);
   localparam logic [FUNC_W-1:0] OP_TPL = FUNC_W'(5);
   localparam logic [FUNC_W-1:0] OP_SQR = FUNC_W'(6);
   localparam logic [FUNC_W-1:0] OP_MUL = FUNC_W'(7);
   localparam logic [FUNC_W-1:0] OP_CVT = FUNC_W'(8);
   localparam logic [FUNC_W-1:0] OP_ICV = FUNC_W'(9);
   localparam logic [FUNC_W-1:0] OP_INV = FUNC_W'(10);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;
   logic               halt_next;

   logic [NREG-1:0]    sb;
   logic [NREG-1:0]    sb_next;
   logic [WBW-1:0]     resv;
   logic [WBW-1:0]     resv_shift;
   logic [WBW-1:0]     resv_next;
   logic [WBW-1:0]     slot_mask;

   logic               inv_busy;
   logic               inv_busy_next;
   logic [REG_W-1:0]   inv_rd;
   logic [REG_W-1:0]   inv_rd_next;
   logic [CNT_W-1:0]   inv_cnt;
   logic [CNT_W-1:0]   inv_cnt_next;

   logic               op_known;
   logic               is_inv;
   logic               raw_hz;
   logic               waw_hz;
   logic               slot_hz;
   logic               inv_hz;
   logic               stall;
   logic               ready_c;
   logic               accept;
   logic               issue;
   logic               retire;

   assign rf_raddr0 = ins.ins_rs0;
   assign rf_raddr1 = ins.ins_rs1;

   // Op class -> one-hot writeback slot (index lat-1); unknown ops have no slot.
   always_comb begin
      op_known  = 1'b1;
      slot_mask = '0;
      case (ins.ins_op)
         OP_ADD, OP_SUB, OP_NEG, OP_DBL: slot_mask = WBW'(1) << (LAT_LIN - 1);
         OP_TPL:                         slot_mask = WBW'(1) << (LAT_TPL - 1);
         OP_SQR, OP_MUL, OP_CVT, OP_ICV: slot_mask = WBW'(1) << (LAT_MUL - 1);
         OP_INV:                         slot_mask = WBW'(1) << (LAT_INV - 1);
         default:                        op_known  = 1'b0;
      endcase
   end

   // Slots are compared against the post-shift view, the same frame the new bit lands in.
   assign resv_shift = resv >> 1;
   assign is_inv     = (ins.ins_op == OP_INV);

   always_comb begin
      raw_hz  = ((ins.ins_rs0 != '0) && sb[ins.ins_rs0]) ||
                ((ins.ins_rs1 != '0) && sb[ins.ins_rs1]);
      waw_hz  = (ins.ins_rd != '0) && sb[ins.ins_rd];
      slot_hz = op_known && (|(resv_shift & slot_mask));
      inv_hz  = is_inv && inv_busy;
      stall   = !ins.ins_halt && (raw_hz || waw_hz || slot_hz || inv_hz);
      ready_c = (state == S_RUN) && !stall;
      accept  = ins.ins_valid && ready_c;
      issue   = accept && !ins.ins_halt && op_known;
      retire  = wen_ex && (waddr_ex != '0);
   end

   assign ins.ins_ready = ready_c;

   // Scoreboard and reservation update; a same-cycle issue set beats a retire clear.
   always_comb begin
      sb_next = sb;
      if (retire) begin
         sb_next[waddr_ex] = 1'b0;
      end
      if (issue && (ins.ins_rd != '0)) begin
         sb_next[ins.ins_rd] = 1'b1;
      end
      resv_next = resv_shift;
      if (issue && (ins.ins_rd != '0)) begin
         resv_next = resv_shift | slot_mask;
      end
   end

   // INV serialisation: released by its retire, or by a countdown when it has no rd.
   always_comb begin
      inv_busy_next = inv_busy;
      inv_rd_next   = inv_rd;
      inv_cnt_next  = inv_cnt;
      if (inv_busy && (inv_rd == '0)) begin
         if (inv_cnt == '0) begin
            inv_busy_next = 1'b0;
         end else begin
            inv_cnt_next = inv_cnt - CNT_W'(1);
         end
      end
      if (retire && inv_busy && (waddr_ex == inv_rd)) begin
         inv_busy_next = 1'b0;
      end
      if (issue && is_inv) begin
         inv_busy_next = 1'b1;
         inv_rd_next   = ins.ins_rd;
         inv_cnt_next  = CNT_W'(LAT_INV);
      end
   end

   // Sequencing: drain completes when nothing is tracked after this edge's updates.
   always_comb begin
      state_next = state;
      halt_next  = 1'b0;
      case (state)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (accept && ins.ins_halt) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((sb_next == '0) && (resv_next == '0)) begin
               state_next = S_HALTED;
               halt_next  = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb       <= '0;
         resv     <= '0;
         inv_busy <= 1'b0;
         inv_rd   <= '0;
         inv_cnt  <= '0;
         ex_valid <= 1'b0;
         halt_ex  <= 1'b0;
         busy     <= 1'b0;
         func_op  <= '0;
         op_0     <= '0;
         op_1     <= '0;
         rn_df    <= '0;
      end else begin
         sb       <= sb_next;
         resv     <= resv_next;
         inv_busy <= inv_busy_next;
         inv_rd   <= inv_rd_next;
         inv_cnt  <= inv_cnt_next;
         ex_valid <= issue;
         halt_ex  <= halt_next;
         busy     <= (state_next == S_RUN) || (state_next == S_DRAIN);
         rn_df    <= issue ? ins.ins_rd : '0;
         if (issue) begin
            func_op <= ins.ins_op;
            op_0    <= rf_rdata0;
            op_1    <= rf_rdata1;
         end
      end
   end

endmodule
